// File: rtl/axi_lite_arbiter_if.sv
// AXI-lite channel bundle used for both requester ports and the shared slave port.
// The master modport is the side that issues addresses; slave is the side that answers.
interface axi_lite_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Serialising IFU/LSU -> single slave AXI-lite arbiter, one transaction in flight,
// fixed LSU-over-IFU priority, with per-channel AW/W completion tracking.
module axi_lite_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    axi_lite_arbiter_if.slave  ifu,
    axi_lite_arbiter_if.slave  lsu,
    axi_lite_arbiter_if.master m
);
    typedef enum logic [2:0] {
        IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_AW, LSU_B
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;

    logic aw_hs, w_hs;
    logic m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    logic ifu_arready, ifu_rvalid;
    logic lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // A beat already accepted by the slave is never offered again, so its handshake
    // can only happen while its done flag is still clear.
    assign aw_hs = (state_q == LSU_AW) && !aw_done_q && m.awready;
    assign w_hs  = (state_q == LSU_AW) && !w_done_q  && m.wready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        strb_d      = strb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        m_awvalid   = 1'b0;
        m_wvalid    = 1'b0;
        m_bready    = 1'b0;
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        case (state_q)
            IDLE: begin
                // The LSU presents AW and W together, so both are sampled at grant.
                if (lsu.awvalid || lsu.wvalid) begin
                    state_d = LSU_AW;
                    addr_d  = lsu.awaddr;
                    data_d  = lsu.wdata;
                    strb_d  = lsu.wstrb;
                end else if (lsu.arvalid) begin
                    state_d = LSU_AR;
                    addr_d  = lsu.araddr;
                end else if (ifu.arvalid) begin
                    state_d = IFU_AR;
                    addr_d  = ifu.araddr;
                end
            end
            IFU_AR: begin
                m_arvalid   = 1'b1;
                ifu_arready = m.arready;
                if (m.arready) state_d = IFU_R;
            end
            IFU_R: begin
                m_rready   = ifu.rready;
                ifu_rvalid = m.rvalid;
                if (m.rvalid && ifu.rready) state_d = IDLE;
            end
            LSU_AR: begin
                m_arvalid   = 1'b1;
                lsu_arready = m.arready;
                if (m.arready) state_d = LSU_R;
            end
            LSU_R: begin
                m_rready   = lsu.rready;
                lsu_rvalid = m.rvalid;
                if (m.rvalid && lsu.rready) state_d = IDLE;
            end
            LSU_AW: begin
                m_awvalid   = !aw_done_q;
                m_wvalid    = !w_done_q;
                lsu_awready = aw_hs;
                lsu_wready  = w_hs;
                aw_done_d   = aw_done_q || aw_hs;
                w_done_d    = w_done_q  || w_hs;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = LSU_B;
            end
            LSU_B: begin
                m_bready   = lsu.bready;
                lsu_bvalid = m.bvalid;
                if (m.bvalid && lsu.bready) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m.araddr  = addr_q;
    assign m.arvalid = m_arvalid;
    assign m.rready  = m_rready;
    assign m.awaddr  = addr_q;
    assign m.awvalid = m_awvalid;
    assign m.wdata   = data_q;
    assign m.wstrb   = strb_q;
    assign m.wvalid  = m_wvalid;
    assign m.bready  = m_bready;

    assign ifu.arready = ifu_arready;
    assign ifu.rdata   = m.rdata;
    assign ifu.rresp   = m.rresp;
    assign ifu.rvalid  = ifu_rvalid;
    assign ifu.awready = 1'b0;
    assign ifu.wready  = 1'b0;
    assign ifu.bresp   = 2'b00;
    assign ifu.bvalid  = 1'b0;

    assign lsu.arready = lsu_arready;
    assign lsu.rdata   = m.rdata;
    assign lsu.rresp   = m.rresp;
    assign lsu.rvalid  = lsu_rvalid;
    assign lsu.awready = lsu_awready;
    assign lsu.wready  = lsu_wready;
    assign lsu.bresp   = m.bresp;
    assign lsu.bvalid  = lsu_bvalid;

    // The fetch unit is read-only; its write channels are tied off above.
    logic unused_ifu_write;
    assign unused_ifu_write = ^{ifu.awaddr, ifu.awvalid, ifu.wdata, ifu.wstrb,
                                ifu.wvalid, ifu.bready};
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: cycle-by-cycle stimulus with hand-computed
// expectations checked by immediate assertions.
module tb_axi_lite_arbiter;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ar_hs_cnt;

    axi_lite_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) ifu_bus ();
    axi_lite_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) lsu_bus ();
    axi_lite_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) m_bus ();

    axi_lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ifu   (ifu_bus),
        .lsu   (lsu_bus),
        .m     (m_bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("check %-22s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Step to 1 time unit after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        ifu_bus.araddr = '0; ifu_bus.arvalid = 0; ifu_bus.rready = 0;
        ifu_bus.awaddr = '0; ifu_bus.awvalid = 0; ifu_bus.wdata = '0;
        ifu_bus.wstrb = '0;  ifu_bus.wvalid = 0;  ifu_bus.bready = 0;
        lsu_bus.araddr = '0; lsu_bus.arvalid = 0; lsu_bus.rready = 0;
        lsu_bus.awaddr = '0; lsu_bus.awvalid = 0; lsu_bus.wdata = '0;
        lsu_bus.wstrb = '0;  lsu_bus.wvalid = 0;  lsu_bus.bready = 0;
        m_bus.arready = 0; m_bus.rdata = '0; m_bus.rresp = 2'b00; m_bus.rvalid = 0;
        m_bus.awready = 0; m_bus.wready = 0; m_bus.bresp = 2'b00; m_bus.bvalid = 0;

        // Reset state, with requests and slave activity present to prove masking
        repeat (2) @(posedge clk_i);
        ifu_bus.arvalid = 1; lsu_bus.awvalid = 1; m_bus.arready = 1; m_bus.rvalid = 1;
        m_bus.awready = 1; m_bus.wready = 1; m_bus.bvalid = 1;
        #3;
        chk("rst_m_valids", {m_bus.arvalid, m_bus.awvalid, m_bus.wvalid}, 32'h0);
        chk("rst_m_readies", {m_bus.rready, m_bus.bready}, 32'h0);
        chk("rst_up_readies", {ifu_bus.arready, lsu_bus.arready, lsu_bus.awready, lsu_bus.wready}, 32'h0);
        chk("rst_up_valids", {ifu_bus.rvalid, lsu_bus.rvalid, lsu_bus.bvalid}, 32'h0);
        chk("rst_addr", m_bus.araddr, 32'h0);
        chk("rst_wdata_strb", {m_bus.wdata[27:0], m_bus.wstrb}, 32'h0);
        ifu_bus.arvalid = 0; lsu_bus.awvalid = 0; m_bus.arready = 0; m_bus.rvalid = 0;
        m_bus.awready = 0; m_bus.wready = 0; m_bus.bvalid = 0;
        cyc(); rst_i = 0;

        // IFU read, zero-wait slave
        cyc();
        ifu_bus.araddr = 32'h8000_0000; ifu_bus.arvalid = 1; ifu_bus.rready = 1;
        m_bus.arready = 1;
        #2; chk("t1_c0_idle_arvalid", m_bus.arvalid, 1'b0);
        cyc(); #2;
        chk("t1_c1_arvalid", m_bus.arvalid, 1'b1);
        chk("t1_c1_araddr", m_bus.araddr, 32'h8000_0000);
        chk("t1_c1_ifu_arready", ifu_bus.arready, 1'b1);
        cyc();
        m_bus.rvalid = 1; m_bus.rdata = 32'h0000_0413; m_bus.rresp = 2'b00;
        #2;
        chk("t1_c2_ifu_rvalid", ifu_bus.rvalid, 1'b1);
        chk("t1_c2_ifu_rdata", ifu_bus.rdata, 32'h0000_0413);
        chk("t1_c2_m_rready", m_bus.rready, 1'b1);
        chk("t1_c2_arvalid", m_bus.arvalid, 1'b0);
        cyc();
        ifu_bus.arvalid = 0; m_bus.rvalid = 0;
        #2;
        chk("t1_c3_idle", {m_bus.arvalid, m_bus.rready, ifu_bus.rvalid}, 32'h0);

        // Simultaneous IFU and LSU reads: LSU first, IFU after one idle cycle
        cyc();
        ifu_bus.araddr = 32'h8000_0004; ifu_bus.arvalid = 1; ifu_bus.rready = 1;
        lsu_bus.araddr = 32'h8000_1000; lsu_bus.arvalid = 1; lsu_bus.rready = 1;
        m_bus.arready = 1;
        #2; chk("t2_c0_idle", m_bus.arvalid, 1'b0);
        cyc(); #2;
        chk("t2_c1_araddr", m_bus.araddr, 32'h8000_1000);
        chk("t2_c1_readies", {lsu_bus.arready, ifu_bus.arready}, 32'h2);
        cyc();
        m_bus.rvalid = 1; m_bus.rdata = 32'hDEAD_BEEF;
        #2;
        chk("t2_c2_rvalids", {lsu_bus.rvalid, ifu_bus.rvalid}, 32'h2);
        chk("t2_c2_lsu_rdata", lsu_bus.rdata, 32'hDEAD_BEEF);
        cyc();
        lsu_bus.arvalid = 0; m_bus.rvalid = 0;
        #2;
        chk("t2_c3_idle", {m_bus.arvalid, lsu_bus.rvalid, ifu_bus.rvalid}, 32'h0);
        cyc(); #2;
        chk("t2_c4_arvalid", m_bus.arvalid, 1'b1);
        chk("t2_c4_araddr", m_bus.araddr, 32'h8000_0004);
        chk("t2_c4_readies", {lsu_bus.arready, ifu_bus.arready}, 32'h1);
        cyc();
        m_bus.rvalid = 1; m_bus.rdata = 32'h0000_0013;
        #2;
        chk("t2_c5_rvalids", {lsu_bus.rvalid, ifu_bus.rvalid}, 32'h1);
        chk("t2_c5_ifu_rdata", ifu_bus.rdata, 32'h0000_0013);
        cyc();
        ifu_bus.arvalid = 0; m_bus.rvalid = 0; m_bus.arready = 0;
        #2;
        chk("t2_c6_idle", m_bus.arvalid, 1'b0);

        // LSU store with AW accepted at once and W delayed two cycles
        cyc();
        lsu_bus.awaddr = 32'h8000_2003; lsu_bus.awvalid = 1;
        lsu_bus.wdata = 32'hA500_0000; lsu_bus.wstrb = 4'b1000; lsu_bus.wvalid = 1;
        lsu_bus.bready = 1; m_bus.awready = 1; m_bus.wready = 0;
        #2; chk("t3_c0_idle", {m_bus.awvalid, m_bus.wvalid}, 32'h0);
        cyc(); #2;
        chk("t3_c1_valids", {m_bus.awvalid, m_bus.wvalid}, 32'h3);
        chk("t3_c1_awaddr", m_bus.awaddr, 32'h8000_2003);
        chk("t3_c1_wdata", m_bus.wdata, 32'hA500_0000);
        chk("t3_c1_wstrb", m_bus.wstrb, 4'b1000);
        chk("t3_c1_up_readies", {lsu_bus.awready, lsu_bus.wready}, 32'h2);
        cyc(); #2;
        chk("t3_c2_valids", {m_bus.awvalid, m_bus.wvalid}, 32'h1);
        chk("t3_c2_lsu_awready", lsu_bus.awready, 1'b0);
        cyc();
        m_bus.wready = 1;
        #2;
        chk("t3_c3_valids", {m_bus.awvalid, m_bus.wvalid}, 32'h1);
        chk("t3_c3_lsu_wready", lsu_bus.wready, 1'b1);
        chk("t3_c3_bready", m_bus.bready, 1'b0);
        cyc();
        m_bus.wready = 0; m_bus.bvalid = 1; m_bus.bresp = 2'b00;
        #2;
        chk("t3_c4_valids", {m_bus.awvalid, m_bus.wvalid}, 32'h0);
        chk("t3_c4_bready_bvalid", {m_bus.bready, lsu_bus.bvalid}, 32'h3);
        cyc();
        lsu_bus.awvalid = 0; lsu_bus.wvalid = 0; m_bus.bvalid = 0; m_bus.awready = 0;
        #2;
        chk("t3_c5_idle", {m_bus.awvalid, m_bus.wvalid, m_bus.bready}, 32'h0);

        // LSU read with a slow response: exactly one AR handshake
        ar_hs_cnt = 0;
        cyc();
        lsu_bus.araddr = 32'h8000_3000; lsu_bus.arvalid = 1; lsu_bus.rready = 1;
        m_bus.arready = 1;
        #2;
        cyc(); #2;
        if (m_bus.arvalid && m_bus.arready) ar_hs_cnt++;
        for (int k = 2; k <= 6; k++) begin
            cyc();
            if (k == 6) begin
                m_bus.rvalid = 1; m_bus.rdata = 32'hCAFE_0001;
            end
            #2;
            if (m_bus.arvalid && m_bus.arready) ar_hs_cnt++;
            if (k == 4) chk("t4_wait_lsu_rvalid", lsu_bus.rvalid, 1'b0);
        end
        chk("t4_c6_lsu_rvalid", lsu_bus.rvalid, 1'b1);
        chk("t4_c6_lsu_rdata", lsu_bus.rdata, 32'hCAFE_0001);
        cyc();
        lsu_bus.arvalid = 0; m_bus.rvalid = 0; m_bus.arready = 0;
        #2;
        chk("t4_ar_handshakes", ar_hs_cnt, 32'd1);

        // Store with SLVERR response and two cycles of bready backpressure
        cyc();
        lsu_bus.awaddr = 32'h8000_4000; lsu_bus.awvalid = 1;
        lsu_bus.wdata = 32'h1234_5678; lsu_bus.wstrb = 4'hF; lsu_bus.wvalid = 1;
        lsu_bus.bready = 0; m_bus.awready = 1; m_bus.wready = 1;
        #2;
        cyc(); #2;
        chk("t5_c1_valids", {m_bus.awvalid, m_bus.wvalid}, 32'h3);
        cyc();
        m_bus.awready = 0; m_bus.wready = 0; m_bus.bvalid = 1; m_bus.bresp = 2'b10;
        #2;
        chk("t5_c2_bready", m_bus.bready, 1'b0);
        chk("t5_c2_bvalid_bresp", {lsu_bus.bvalid, lsu_bus.bresp}, 32'h6);
        cyc(); #2;
        chk("t5_c3_bready", m_bus.bready, 1'b0);
        cyc();
        lsu_bus.bready = 1;
        #2;
        chk("t5_c4_bready", m_bus.bready, 1'b1);
        chk("t5_c4_bresp", lsu_bus.bresp, 2'b10);
        cyc();
        lsu_bus.awvalid = 0; lsu_bus.wvalid = 0; m_bus.bvalid = 0; m_bus.bresp = 2'b00;
        #2;
        chk("t5_c5_idle", {m_bus.bready, m_bus.awvalid, lsu_bus.bvalid}, 32'h0);

        // Reset asserted while waiting in LSU_R
        cyc();
        lsu_bus.araddr = 32'h8000_5000; lsu_bus.arvalid = 1; lsu_bus.rready = 1;
        m_bus.arready = 1;
        #2;
        cyc(); #2;
        chk("t6_c1_arvalid", m_bus.arvalid, 1'b1);
        cyc();
        m_bus.arready = 0; m_bus.rvalid = 1; m_bus.rdata = 32'h5555_AAAA;
        #2;
        chk("t6_c2_rready_rvalid", {m_bus.rready, lsu_bus.rvalid}, 32'h3);
        rst_i = 1;
        #1;
        chk("t6_rst_async", {m_bus.rready, lsu_bus.rvalid, m_bus.arvalid, m_bus.awvalid,
                             m_bus.wvalid, m_bus.bready}, 32'h0);
        cyc();
        lsu_bus.arvalid = 0; lsu_bus.rready = 0; m_bus.rvalid = 0;
        cyc();
        rst_i = 0;
        ifu_bus.araddr = 32'h8000_0100; ifu_bus.arvalid = 1; ifu_bus.rready = 1;
        m_bus.arready = 1;
        #2;
        chk("t6_post_rst_idle", {m_bus.arvalid, m_bus.rready}, 32'h0);
        cyc(); #2;
        chk("t6_post_rst_arvalid", m_bus.arvalid, 1'b1);
        chk("t6_post_rst_araddr", m_bus.araddr, 32'h8000_0100);
        cyc();
        ifu_bus.arvalid = 0; m_bus.arready = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
